// File: rtl/bitop_pkg.sv
// Shared opcodes, FSM encoding and helpers for the slice-serial bitop unit.
package bitop_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NOTA = 3'd4;
  localparam logic [2:0] OP_RAND = 3'd5;
  localparam logic [2:0] OP_RNOR = 3'd6;
  localparam logic [2:0] OP_RXOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Identity element of the running reduction: 1 for AND, 0 for OR/XOR.
  function automatic logic red_init(input logic [2:0] op);
    return (op == OP_RAND);
  endfunction

endpackage

// File: rtl/bitop_slice_alu.sv
// Combinational SLICE-bit bitwise ALU with per-slice reductions of operand a.
module bitop_slice_alu
  import bitop_pkg::*;
#(
  parameter int unsigned SLICE = 4
) (
  input  logic [2:0]       op_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic [SLICE-1:0] res_o,
  output logic             red_and_o,
  output logic             red_or_o,
  output logic             red_xor_o
);

  // Bitwise result; reduction opcodes pass a through since only the reductions matter.
  always_comb begin
    res_o = a_i;
    unique case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_XNOR: res_o = ~(a_i ^ b_i);
      OP_NOTA: res_o = ~a_i;
      default: res_o = a_i;
    endcase
  end

  assign red_and_o = &a_i;
  assign red_or_o  = |a_i;
  assign red_xor_o = ^a_i;

endmodule

// File: rtl/bitop_seq_arbiter.sv
// Two-port round-robin front end driving a slice-serial bitop ALU, LSB slice first.
module bitop_seq_arbiter
  import bitop_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [WIDTH-1:0] resp_data_o
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NSLICE - 1);

  if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : gen_bad_cfg
    $error("bitop_seq_arbiter: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             id_q, id_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             acc_q, acc_d;

  logic             gnt_any, gnt_id;
  logic [2:0]       gnt_op;
  logic [SLICE-1:0] a_sl, b_sl, alu_res;
  logic             red_and, red_or, red_xor, acc_nxt;

  // Round-robin grant: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    gnt_any = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      gnt_id = ~ptr_q;
    end else begin
      gnt_id = req1_valid_i;
    end
    gnt_op = gnt_id ? req1_op_i : req0_op_i;
  end

  // Select the operand slice addressed by the slice counter.
  always_comb begin
    a_sl = a_q[SLICE-1:0];
    b_sl = b_q[SLICE-1:0];
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt_q == CntW'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
  end

  bitop_slice_alu #(
    .SLICE(SLICE)
  ) u_alu (
    .op_i     (op_q),
    .a_i      (a_sl),
    .b_i      (b_sl),
    .res_o    (alu_res),
    .red_and_o(red_and),
    .red_or_o (red_or),
    .red_xor_o(red_xor)
  );

  // Fold the current slice reduction into the accumulator.
  always_comb begin
    unique case (op_q)
      OP_RAND: acc_nxt = acc_q & red_and;
      OP_RNOR: acc_nxt = acc_q | red_or;
      OP_RXOR: acc_nxt = acc_q ^ red_xor;
      default: acc_nxt = acc_q;
    endcase
  end

  // FSM next state, operand capture, slice sequencing and handshake outputs.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    res_d        = res_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          req0_ready_o = ~gnt_id;
          req1_ready_o = gnt_id;
          op_d         = gnt_op;
          a_d          = gnt_id ? req1_a_i : req0_a_i;
          b_d          = gnt_id ? req1_b_i : req0_b_i;
          id_d         = gnt_id;
          cnt_d        = '0;
          acc_d        = red_init(gnt_op);
          ptr_d        = gnt_id;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_nxt;
        if (op_q < OP_RAND) begin
          for (int k = 0; k < NSLICE; k++) begin
            if (cnt_q == CntW'(k)) begin
              res_d[k*SLICE +: SLICE] = alu_res;
            end
          end
        end
        if (cnt_q == CntLast) begin
          // Counter holds here; it is only cleared by the next accept.
          state_d = ST_DONE;
          if (op_q >= OP_RAND) begin
            res_d    = '0;
            res_d[0] = (op_q == OP_RNOR) ? ~acc_nxt : acc_nxt;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_DONE: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign resp_data_o = res_q;
  assign resp_id_o   = id_q;

endmodule
